// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single memory port between the Icache (requester 0) and the
//   Dcache (requester 1). Grant is combinational; a priority flop alternates
//   the winner after each contested, accepted request. Accepted loads record
//   their tag's owner so returning data can be steered to the right cache.
//
// Ports
//   clock, reset                 clock, async active-low reset
//   icache_command/addr          Icache request (STORE is ignored)
//   dcache_command/addr/wdata    Dcache request
//   proc2mem_command/addr/data   request driven to memory
//   mem2proc_response            acceptance tag from memory (0 = rejected)
//   mem2proc_data/tag            load return from memory (tag 0 = none)
//   icache_/dcache_response      acceptance tag routed to the granted cache
//   icache_/dcache_data/tag      return data routed to the tag's owner
//   grant                        one-hot grant, {dcache, icache}
//   unmatched_err                sticky: a tag returned with no owner

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module mem_arbiter #(
   parameter int TAG_W = 4,
   parameter int NREQ  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        icache_command,
   input  logic [`XLEN-1:0]  icache_addr,
   input  logic [1:0]        dcache_command,
   input  logic [`XLEN-1:0]  dcache_addr,
   input  logic [63:0]       dcache_wdata,
   output logic [1:0]        proc2mem_command,
   output logic [`XLEN-1:0]  proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   input  logic [TAG_W-1:0]  mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [TAG_W-1:0]  mem2proc_tag,
   output logic [TAG_W-1:0]  icache_response,
   output logic [TAG_W-1:0]  dcache_response,
   output logic [63:0]       icache_data,
   output logic [63:0]       dcache_data,
   output logic [TAG_W-1:0]  icache_tag,
   output logic [TAG_W-1:0]  dcache_tag,
   output logic [NREQ-1:0]   grant,
   output logic              unmatched_err
);

   localparam int NTAG = 1 << TAG_W;

   logic            icache_act, dcache_act;
   logic            gnt_i, gnt_d;
   logic            ret_hit, ret_owner, ret_valid_tag, load_accept;
   logic            prio_q, prio_d;
   logic            err_q, err_d;
   logic [NTAG-1:0] valid_q, valid_d;
   logic [NTAG-1:0] owner_q, owner_d;

   // Requests are masked while in reset so the bus and grant read idle.
   always_comb begin
      icache_act = reset && (icache_command == `BUS_LOAD);
      dcache_act = reset && ((dcache_command == `BUS_LOAD) ||
                             (dcache_command == `BUS_STORE));
      gnt_i = icache_act && (!dcache_act || !prio_q);
      gnt_d = dcache_act && (!icache_act ||  prio_q);
   end

   assign grant         = {gnt_d, gnt_i};
   assign unmatched_err = err_q;

   always_comb begin
      proc2mem_command = `BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (gnt_i) begin
         proc2mem_command = `BUS_LOAD;
         proc2mem_addr    = icache_addr;
      end else if (gnt_d) begin
         proc2mem_command = dcache_command;
         proc2mem_addr    = dcache_addr;
         proc2mem_data    = dcache_wdata;
      end
      icache_response = gnt_i ? mem2proc_response : '0;
      dcache_response = gnt_d ? mem2proc_response : '0;
   end

   always_comb begin
      ret_valid_tag = (mem2proc_tag != '0);
      ret_hit       = ret_valid_tag && valid_q[mem2proc_tag];
      ret_owner     = owner_q[mem2proc_tag];
      icache_tag    = (ret_hit && !ret_owner) ? mem2proc_tag  : '0;
      icache_data   = (ret_hit && !ret_owner) ? mem2proc_data : '0;
      dcache_tag    = (ret_hit &&  ret_owner) ? mem2proc_tag  : '0;
      dcache_data   = (ret_hit &&  ret_owner) ? mem2proc_data : '0;
   end

   always_comb begin
      load_accept = (proc2mem_command == `BUS_LOAD) && (mem2proc_response != '0);
      prio_d  = prio_q;
      err_d   = err_q;
      valid_d = valid_q;
      owner_d = owner_q;
      // Contested and accepted: hand priority to whoever lost this round.
      if (icache_act && dcache_act && (mem2proc_response != '0))
         prio_d = gnt_i;
      if (ret_hit)
         valid_d[mem2proc_tag] = 1'b0;
      else if (ret_valid_tag)
         err_d = 1'b1;
      // Applied after the free so a same-tag allocate wins.
      if (load_accept) begin
         valid_d[mem2proc_response] = 1'b1;
         owner_d[mem2proc_response] = gnt_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prio_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= '0;
         owner_q <= '0;
      end else begin
         prio_q  <= prio_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

endmodule
